painterengine_gpu_dma_writer: RTL and testbench

AXI4 write-master DMA; write direction of the GPU memory path. Routes one of 4 one-hot-selected stream sources to memory at a word-aligned address for a length in 32-bit words. Splits the transfer into INCR bursts (<=256 beats, never crossing a 1 KB boundary); each burst waits for BRESP. Reports sticky done/error to the GPU controller.

---
 rtl/painterengine_gpu_dma_writer_pkg.sv | 49 ++++
 rtl/painterengine_gpu_dma_writer_if.sv | 41 ++++
 rtl/painterengine_gpu_dma_burst_calc.sv | 22 ++
 rtl/painterengine_gpu_dma_writer.sv | 191 +++++++++++++++++++
 tb/tb_painterengine_gpu_dma_writer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/painterengine_gpu_dma_writer_pkg.sv
// Shared GPU DMA definitions: FSM encodings, error codes, AXI write sideband constants
// and one-hot source-select helpers (also used by the reader side).
package painterengine_gpu_dma_writer_pkg;

  typedef enum logic [2:0] {
    ST_ROUTING     = 3'd0,
    ST_PARAM_CHECK = 3'd1,
    ST_CALC        = 3'd2,
    ST_ADDR        = 3'd3,
    ST_DATA        = 3'd4,
    ST_DONE        = 3'd5,
    ST_RESP        = 3'd6,
    ST_ERROR       = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_ROUTER     = 3'd1,
    ERR_ADDRESS    = 3'd2,
    ERR_AW_TIMEOUT = 3'd3,
    ERR_W_TIMEOUT  = 3'd4,
    ERR_PROTOCOL   = 3'd5,
    ERR_BRESP      = 3'd6,
    ERR_B_TIMEOUT  = 3'd7
  } err_t;

  localparam logic       AXI_ID         = 1'b0;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic       AXI_LOCK       = 1'b0;
  localparam logic [3:0] AXI_CACHE      = 4'b0010;
  localparam logic [2:0] AXI_PROT       = 3'b000;
  localparam logic [3:0] AXI_QOS        = 4'b0000;
  localparam logic [3:0] AXI_STRB_ALL   = 4'hF;

  function automatic logic is_onehot4(input logic [3:0] r);
    return (r != 4'd0) && ((r & (r - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (r[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_writer_if.sv
// AXI4 write channels (AW/W/B) between the GPU DMA writer (master) and memory (slave).
interface painterengine_gpu_dma_writer_if;
  import painterengine_gpu_dma_writer_pkg::*;

  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awid;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic        bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awlen, awid, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awid, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/painterengine_gpu_dma_burst_calc.sv
// Combinational burst sizing: largest INCR burst from the current offset that fits the
// remaining length and the MAX_BURST-aligned word window, so it never crosses 1 KB.
module painterengine_gpu_dma_burst_calc #(
  parameter int MAX_BURST = 256
) (
  input  logic [31:0] address,
  input  logic [31:0] offset,
  input  logic [31:0] length,
  output logic [8:0]  burst_len,
  output logic [31:0] burst_addr
);
  logic [7:0]  word_pos;
  logic [8:0]  room;
  logic [31:0] remain;

  // Position of the next word inside its MAX_BURST window; 8 bits suffice since MAX_BURST <= 256.
  assign word_pos   = (address[9:2] + offset[7:0]) & 8'(MAX_BURST - 1);
  assign room       = 9'(MAX_BURST) - {1'b0, word_pos};
  assign remain     = length - offset;
  assign burst_len  = (remain < {23'd0, room}) ? remain[8:0] : room;
  assign burst_addr = address + (offset << 2);
endmodule

// File: rtl/painterengine_gpu_dma_writer.sv
// AXI4 write-master DMA: one-hot-selected source -> memory in <=MAX_BURST, 1KB-safe bursts, one burst in flight.
// Data path is combinational (source valid -> WVALID, WREADY -> pop); BRESP checked only with PAINTERENGINE_GPU_WRITER_BRESP_CHECK_EN.
module painterengine_gpu_dma_writer
  import painterengine_gpu_dma_writer_pkg::*;
#(
  parameter int TIMEOUT_BIT = 18,
  parameter int MAX_BURST   = 256
) (
  input  logic          i_wire_clock,
  input  logic          i_wire_resetn,
  output logic          o_wire_done,
  input  logic [127:0]  i_wire_address,
  input  logic [127:0]  i_wire_length,
  input  logic [3:0]    i_wire_router,
  input  logic [127:0]  i_wire_data,
  input  logic [3:0]    i_wire_data_valid,
  output logic [3:0]    o_wire_data_next,
  output logic          o_wire_error,
  output logic [2:0]    o_wire_error_type,
  painterengine_gpu_dma_writer_if.master m_axi
);
  state_t state, state_nxt;
  err_t   err_q, err_nxt;

  logic [31:0] address, length, offset, awaddr_q;
  logic [1:0]  index, route_idx;
  logic [8:0]  burst, beat, burst_m1;
  logic [8:0]  calc_len;
  logic [31:0] calc_addr;
  logic [TIMEOUT_BIT:0] stall;

  logic aw_hs, w_hs, b_hs, progress, in_wait, timed_out, bresp_bad;
  logic unused_sink;

  assign route_idx = onehot_index(i_wire_router);

  painterengine_gpu_dma_burst_calc #(.MAX_BURST(MAX_BURST)) u_burst_calc (
    .address    (address),
    .offset     (offset),
    .length     (length),
    .burst_len  (calc_len),
    .burst_addr (calc_addr)
  );

  assign burst_m1 = burst - 9'd1;

  assign m_axi.awvalid = (state == ST_ADDR);
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = burst_m1[7:0];
  assign m_axi.awid    = AXI_ID;
  assign m_axi.awsize  = AXI_SIZE_WORD;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = AXI_LOCK;
  assign m_axi.awcache = AXI_CACHE;
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.awqos   = AXI_QOS;

  assign m_axi.wvalid = (state == ST_DATA) && i_wire_data_valid[index];
  assign m_axi.wdata  = (state == ST_DATA) ? i_wire_data[{index, 5'd0} +: 32] : 32'd0;
  assign m_axi.wstrb  = AXI_STRB_ALL;
  assign m_axi.wlast  = (state == ST_DATA) && (beat == burst_m1);
  assign m_axi.bready = (state == ST_RESP);

  assign aw_hs     = m_axi.awvalid && m_axi.awready;
  assign w_hs      = m_axi.wvalid && m_axi.wready;
  assign b_hs      = m_axi.bready && m_axi.bvalid;
  assign progress  = aw_hs || w_hs || b_hs;
  assign in_wait   = (state inside {ST_ADDR, ST_DATA, ST_RESP});
  // A handshake in the trip cycle still counts as progress.
  assign timed_out = stall[TIMEOUT_BIT] && !progress;

`ifdef PAINTERENGINE_GPU_WRITER_BRESP_CHECK_EN
  assign bresp_bad = (m_axi.bresp != 2'b00);
`else
  assign bresp_bad = 1'b0;
`endif

  assign unused_sink = ^{m_axi.bid, m_axi.bresp, burst_m1[8]};

  assign o_wire_done       = (state == ST_DONE);
  assign o_wire_error      = (state == ST_ERROR);
  assign o_wire_error_type = err_q;

  always_comb begin
    o_wire_data_next        = 4'd0;
    o_wire_data_next[index] = w_hs;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    unique case (state)
      ST_ROUTING: begin
        if (is_onehot4(i_wire_router)) begin
          state_nxt = ST_PARAM_CHECK;
        end else begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_ROUTER;
        end
      end
      ST_PARAM_CHECK: begin
        if ((address[1:0] != 2'b00) || (length == 32'd0)) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_ADDRESS;
        end else begin
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (aw_hs) begin
          state_nxt = ST_DATA;
        end else if (timed_out) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_AW_TIMEOUT;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          if (m_axi.wlast) state_nxt = ST_RESP;
        end else if (timed_out) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_W_TIMEOUT;
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          if (bresp_bad) begin
            state_nxt = ST_ERROR;
            err_nxt   = ERR_BRESP;
          end else if (offset >= length) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_CALC;
          end
        end else if (timed_out) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_B_TIMEOUT;
        end
      end
      default: ;
    endcase
    // Only one burst is ever outstanding, so a response anywhere else is a slave fault.
    if (m_axi.bvalid && !(state inside {ST_RESP, ST_DONE, ST_ERROR})) begin
      state_nxt = ST_ERROR;
      err_nxt   = ERR_PROTOCOL;
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state    <= ST_ROUTING;
      err_q    <= ERR_NONE;
      address  <= 32'd0;
      length   <= 32'd0;
      index    <= 2'd0;
      offset   <= 32'd0;
      awaddr_q <= 32'd0;
      burst    <= 9'd0;
      beat     <= 9'd0;
      stall    <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;

      if (progress || !in_wait) stall <= '0;
      else                      stall <= stall + 1'b1;

      unique case (state)
        ST_ROUTING: begin
          address <= i_wire_address[{route_idx, 5'd0} +: 32];
          length  <= i_wire_length[{route_idx, 5'd0} +: 32];
          index   <= route_idx;
        end
        ST_PARAM_CHECK: offset <= 32'd0;
        ST_CALC: begin
          burst    <= calc_len;
          awaddr_q <= calc_addr;
        end
        ST_ADDR: if (aw_hs) beat <= 9'd0;
        ST_DATA: begin
          if (w_hs) begin
            if (m_axi.wlast) offset <= offset + {23'd0, burst};
            else             beat   <= beat + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_painterengine_gpu_dma_writer.sv
// Scoreboard bench: directed jobs push expected AW/W beats; a monitor pops and compares on every
// handshake while a responder models the AXI slave and the four stream sources.
`timescale 1ns/1ps
module tb_painterengine_gpu_dma_writer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] address = '0;
  logic [127:0] length = '0;
  logic [127:0] data = '0;
  logic [3:0]   router = 4'd0;
  logic [3:0]   data_valid = 4'd0;
  logic [3:0]   data_next;
  logic         done, error;
  logic [2:0]   error_type;

  always #5 clk = ~clk;

  painterengine_gpu_dma_writer_if axi();

  painterengine_gpu_dma_writer #(.TIMEOUT_BIT(8), .MAX_BURST(256)) dut (
    .i_wire_clock      (clk),
    .i_wire_resetn     (rst_n),
    .o_wire_done       (done),
    .i_wire_address    (address),
    .i_wire_length     (length),
    .i_wire_router     (router),
    .i_wire_data       (data),
    .i_wire_data_valid (data_valid),
    .o_wire_data_next  (data_next),
    .o_wire_error      (error),
    .o_wire_error_type (error_type),
    .m_axi             (axi)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct { logic [31:0] dat; logic last; } w_exp_t;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];
  int tests = 0;
  int fails = 0;
  int aw_fires = 0;
  int pops[4] = '{default: 0};
  int exp_n;

  bit aw_block = 1'b0, w_random = 1'b0, v_toggle = 1'b0, b_block = 1'b0;
  logic [1:0] bresp_val = 2'b00;

  function automatic logic [31:0] pat(input int k, input int n);
    return 32'hA000_0000 | (32'(k) << 24) | 32'(n);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // AXI slave + stream sources: sample at negedge, drive #1 after posedge.
  initial begin
    int   pend_b;
    bit   phase;
    logic wlast_fire, b_fire;
    logic [3:0] npop;
    pend_b = 0;
    phase = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
    axi.bresp = 2'b00; axi.bid = 1'b0;
    forever begin
      @(negedge clk);
      wlast_fire = axi.wvalid && axi.wready && axi.wlast;
      b_fire     = axi.bvalid && axi.bready;
      npop       = data_next;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend_b = 0;
        pops = '{default: 0};
      end else begin
        if (wlast_fire) pend_b++;
        if (b_fire) pend_b--;
        for (int k = 0; k < 4; k++) if (npop[k]) pops[k]++;
      end
      phase = ~phase;
      axi.awready = !aw_block;
      axi.wready  = w_random ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.bvalid  = (pend_b > 0) && !b_block;
      axi.bresp   = bresp_val;
      for (int k = 0; k < 4; k++) data[k*32 +: 32] = pat(k, pops[k]);
      data_valid = v_toggle ? {4{phase}} : 4'hF;
    end
  end

  // Monitor: every AW / W handshake pops the scoreboard.
  initial begin
    aw_exp_t ea;
    w_exp_t  ew;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_fires = 0;
      end else begin
        if (axi.awvalid && axi.awready) begin
          aw_fires++;
          if (aw_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL aw_unexpected: got awaddr 0x%0h awlen %0d, expected no burst", axi.awaddr, axi.awlen);
          end else begin
            ea = aw_q.pop_front();
            check("awaddr", 64'(axi.awaddr), 64'(ea.addr));
            check("awlen", 64'(axi.awlen), 64'(ea.len));
          end
        end
        if (axi.wvalid && axi.wready) begin
          if (w_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL w_unexpected: got wdata 0x%0h, expected no beat", axi.wdata);
          end else begin
            ew = w_q.pop_front();
            check("wdata", 64'(axi.wdata), 64'(ew.dat));
            check("wlast", 64'(axi.wlast), 64'(ew.last));
            check("data_next", 64'(data_next), 64'(router));
          end
        end
      end
    end
  end

  task automatic begin_job(input logic [3:0] r, input int slot, input logic [31:0] a, input logic [31:0] l);
    rst_n = 1'b0;
    aw_q.delete();
    w_q.delete();
    exp_n = 0;
    router = r;
    for (int k = 0; k < 4; k++) begin
      address[k*32 +: 32] = 32'h0000_4000 + 32'(k) * 32'h100;
      length[k*32 +: 32]  = 32'd7 + 32'(k);
    end
    address[slot*32 +: 32] = a;
    length[slot*32 +: 32]  = l;
    repeat (3) @(posedge clk);
  endtask

  task automatic release_reset();
    #1 rst_n = 1'b1;
  endtask

  task automatic push_burst(input int src, input logic [31:0] a, input int beats);
    aw_exp_t ea;
    w_exp_t  ew;
    ea.addr = a;
    ea.len  = 8'(beats - 1);
    aw_q.push_back(ea);
    for (int i = 0; i < beats; i++) begin
      ew.dat  = pat(src, exp_n);
      ew.last = (i == beats - 1);
      w_q.push_back(ew);
      exp_n++;
    end
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (!(done || error)) begin
      tests++; fails++;
      $display("FAIL %s_wait: got no done/error after %0d cycles, expected one", name, budget);
    end
  endtask

  task automatic finish_job(input string name, input logic e_done, input logic e_err,
                            input logic [2:0] e_type, input int src, input int e_pops);
    @(negedge clk);
    check({name, "_done"}, 64'(done), 64'(e_done));
    check({name, "_error"}, 64'(error), 64'(e_err));
    check({name, "_type"}, 64'(error_type), 64'(e_type));
    check({name, "_aw_left"}, 64'(aw_q.size()), 64'd0);
    check({name, "_w_left"}, 64'(w_q.size()), 64'd0);
    check({name, "_pops"}, 64'(pops[src]), 64'(e_pops));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state and constant sideband.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_status", 64'({done, error, error_type}), 64'd0);
    check("rst_handshake", 64'({axi.awvalid, axi.wvalid, axi.bready, data_next}), 64'd0);
    check("sideband", 64'({axi.awid, axi.awsize, axi.awburst, axi.awlock, axi.awcache,
                           axi.awprot, axi.awqos, axi.wstrb}),
          64'({1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000, 4'hF}));

    // Single 16-beat burst from source 1.
    begin_job(4'b0010, 1, 32'h0000_1000, 32'd16);
    push_burst(1, 32'h0000_1000, 16);
    release_reset();
    wait_end("single", 500);
    finish_job("single", 1'b1, 1'b0, 3'd0, 1, 16);

    // 1 KB splitting: 4 words to boundary, then 256, then 40.
    begin_job(4'b0001, 0, 32'h0000_13F0, 32'd300);
    push_burst(0, 32'h0000_13F0, 4);
    push_burst(0, 32'h0000_1400, 256);
    push_burst(0, 32'h0000_1800, 40);
    release_reset();
    wait_end("split", 3000);
    finish_job("split", 1'b1, 1'b0, 3'd0, 0, 300);

    // Bad router: no burst must ever be issued.
    begin_job(4'b0110, 1, 32'h0000_1000, 32'd16);
    release_reset();
    wait_end("router", 100);
    finish_job("router", 1'b0, 1'b1, 3'd1, 1, 0);
    check("router_aw_fires", 64'(aw_fires), 64'd0);

    // Misaligned address and zero length.
    begin_job(4'b0001, 0, 32'h0000_1002, 32'd4);
    release_reset();
    wait_end("misalign", 100);
    finish_job("misalign", 1'b0, 1'b1, 3'd2, 0, 0);
    begin_job(4'b0001, 0, 32'h0000_1000, 32'd0);
    release_reset();
    wait_end("zero_len", 100);
    finish_job("zero_len", 1'b0, 1'b1, 3'd2, 0, 0);

    // Bursty source and random WREADY.
    v_toggle = 1'b1;
    w_random = 1'b1;
    begin_job(4'b1000, 3, 32'h0000_2000, 32'd64);
    push_burst(3, 32'h0000_2000, 64);
    release_reset();
    wait_end("random", 3000);
    finish_job("random", 1'b1, 1'b0, 3'd0, 3, 64);
    v_toggle = 1'b0;
    w_random = 1'b0;

    // AW never accepted -> AW timeout.
    aw_block = 1'b1;
    begin_job(4'b0100, 2, 32'h0000_3000, 32'd8);
    release_reset();
    wait_end("aw_timeout", 2000);
    finish_job("aw_timeout", 1'b0, 1'b1, 3'd3, 2, 0);
    aw_block = 1'b0;

    // SLVERR on the first of two bursts.
    bresp_val = 2'b10;
    begin_job(4'b0001, 0, 32'h0000_13F0, 32'd8);
    push_burst(0, 32'h0000_13F0, 4);
`ifdef PAINTERENGINE_GPU_WRITER_BRESP_CHECK_EN
    release_reset();
    wait_end("slverr", 500);
    finish_job("slverr", 1'b0, 1'b1, 3'd6, 0, 4);
`else
    push_burst(0, 32'h0000_1400, 4);
    release_reset();
    wait_end("slverr", 500);
    finish_job("slverr", 1'b1, 1'b0, 3'd0, 0, 8);
`endif
    bresp_val = 2'b00;

    // Response never arrives -> B timeout.
    b_block = 1'b1;
    begin_job(4'b0001, 0, 32'h0000_1000, 32'd4);
    push_burst(0, 32'h0000_1000, 4);
    release_reset();
    wait_end("b_timeout", 2000);
    finish_job("b_timeout", 1'b0, 1'b1, 3'd7, 0, 4);
    b_block = 1'b0;

    // Reset in the middle of the data phase, then the same job again.
    begin_job(4'b0100, 2, 32'h0000_2000, 32'd64);
    push_burst(2, 32'h0000_2000, 64);
    release_reset();
    n = 0;
    while (pops[2] < 10 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("midrst_reached_data", 64'(pops[2] >= 10), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({axi.awvalid, axi.wvalid, axi.bready, done, error, data_next}), 64'd0);
    begin_job(4'b0100, 2, 32'h0000_2000, 32'd64);
    push_burst(2, 32'h0000_2000, 64);
    release_reset();
    wait_end("rerun", 1000);
    finish_job("rerun", 1'b1, 1'b0, 3'd0, 2, 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
